alu: RTL and testbench

The `alu` block is the 8-bit arithmetic unit of the tiny RISC CPU datapath. It sits between the register/accumulator read ports and the write-back mux. It performs one of three operations on operands `a` and `b`, selected by the decoder control lines `pass` and `add`: pass `a` through, add `a + b`, or drive zero. The result is registered, so it is available one clock after the operands and controls are presented. Optional status flags (zero, carry, overflow) feed the branch logic.

---
 rtl/alu.sv | 75 +++++++
 tb/tb_alu.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit datapath ALU: pass a / a+b / zero; zero/carry/ovf flags built only with ALU_FLAGS_EN.
// Latency: exactly 1 cycle, result and flags registered on every rising edge.
// Backpressure: none; accepts one operation per cycle with no hold or enable.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       pass,
    input  logic       add,
    output logic [7:0] alu_out
`ifdef ALU_FLAGS_EN
    ,
    output logic       zero,
    output logic       carry,
    output logic       ovf
`endif
);

    logic [8:0] w_sum;
    logic [7:0] w_result;
    logic [7:0] r_out;

    assign w_sum = {1'b0, a} + {1'b0, b};

    // pass has priority over add; neither selected yields zero
    always_comb begin
        w_result = 8'h00;
        if (pass) begin
            w_result = a;
        end else if (add) begin
            w_result = w_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 8'h00;
        end else begin
            r_out <= w_result;
        end
    end

    assign alu_out = r_out;

`ifdef ALU_FLAGS_EN
    logic w_add_sel;
    logic w_carry;
    logic w_ovf;
    logic r_zero;
    logic r_carry;
    logic r_ovf;

    assign w_add_sel = !pass && add;
    assign w_carry   = w_add_sel && w_sum[8];
    assign w_ovf     = w_add_sel && (a[7] == b[7]) && (w_sum[7] != a[7]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_zero  <= (w_result == 8'h00);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign zero  = r_zero;
    assign carry = r_carry;
    assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results queued at issue, checked one cycle later.
module tb_alu;

    typedef struct packed {
        logic [7:0] out;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       pass;
    logic       add;
    logic [7:0] alu_out;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       carry;
    logic       ovf;
`endif

    int   total;
    int   bad;
    exp_t q[$];

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .pass    (pass),
        .add     (add),
        .alu_out (alu_out)
`ifdef ALU_FLAGS_EN
        ,
        .zero    (zero),
        .carry   (carry),
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the arithmetic definition (signed range check for overflow).
    function automatic exp_t model(input logic p, input logic ad, input logic [7:0] aa, input logic [7:0] bb);
        exp_t e;
        int   us;
        int   ss;
        us = int'(aa) + int'(bb);
        ss = int'($signed(aa)) + int'($signed(bb));
        e.c = 1'b0;
        e.v = 1'b0;
        if (p) begin
            e.out = aa;
        end else if (ad) begin
            e.out = us[7:0];
            e.c   = (us > 255);
            e.v   = (ss > 127) || (ss < -128);
        end else begin
            e.out = 8'h00;
        end
        e.z = (e.out == 8'h00);
        return e;
    endfunction

    task automatic drive(input logic p, input logic ad, input logic [7:0] aa, input logic [7:0] bb, input exp_t e);
        pass = p;
        add  = ad;
        a    = aa;
        b    = bb;
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        pass  = 1'b0;
        add   = 1'b1;
        a     = 8'h55;
        b     = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (alu_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_out[%0d] got=%02h exp=00", i, alu_out);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({zero, carry, ovf} !== 3'b100) begin
                bad++;
                $display("FAIL reset_flags[%0d] got=%b exp=100", i, {zero, carry, ovf});
            end
`endif
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'h55, 8'h33, '{8'h88, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (alu_out !== e.out) begin
            bad++;
            $display("FAIL reset_release_out got=%02h exp=%02h", alu_out, e.out);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
            bad++;
            $display("FAIL reset_release_flags got=%b exp=%b", {zero, carry, ovf}, {e.z, e.c, e.v});
        end
`endif
    endtask

    task automatic test_pass();
        exp_t e;
        logic tadd[2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, tadd[i], 8'hA5, 8'h3C, '{8'hA5, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (alu_out !== e.out) begin
                bad++;
                $display("FAIL pass_out[%0d] got=%02h exp=%02h", i, alu_out, e.out);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
                bad++;
                $display("FAIL pass_flags[%0d] got=%b exp=%b", i, {zero, carry, ovf}, {e.z, e.c, e.v});
            end
`endif
        end
    endtask

    task automatic test_add();
        exp_t e;
        logic [7:0] ta[3] = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb[3] = '{8'h01, 8'h01, 8'h80};
        exp_t       te[3] = '{'{8'h00, 1'b1, 1'b1, 1'b0},
                              '{8'h80, 1'b0, 1'b0, 1'b1},
                              '{8'h00, 1'b1, 1'b1, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, ta[i], tb[i], te[i]);
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (alu_out !== e.out) begin
                bad++;
                $display("FAIL add_out[%0d] got=%02h exp=%02h", i, alu_out, e.out);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
                bad++;
                $display("FAIL add_flags[%0d] got=%b exp=%b", i, {zero, carry, ovf}, {e.z, e.c, e.v});
            end
`endif
        end
    endtask

    task automatic test_default();
        exp_t e;
        drive(1'b0, 1'b0, 8'h12, 8'h34, '{8'h00, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (alu_out !== e.out) begin
            bad++;
            $display("FAIL default_out got=%02h exp=%02h", alu_out, e.out);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
            bad++;
            $display("FAIL default_flags got=%b exp=%b", {zero, carry, ovf}, {e.z, e.c, e.v});
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic       tp[3] = '{1'b1, 1'b0, 1'b0};
        logic       td[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] tb[3] = '{8'h77, 8'h20, 8'h20};
        logic [7:0] tx[3] = '{8'h10, 8'h30, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(tp[i], td[i], 8'h10, tb[i], '{tx[i], (tx[i] == 8'h00), 1'b0, 1'b0});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (alu_out !== e.out) begin
                bad++;
                $display("FAIL b2b_out[%0d] got=%02h exp=%02h", i, alu_out, e.out);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
                bad++;
                $display("FAIL b2b_flags[%0d] got=%b exp=%b", i, {zero, carry, ovf}, {e.z, e.c, e.v});
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        drive(1'b0, 1'b1, 8'h10, 8'h20, '{8'h30, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (alu_out !== e.out) begin
            bad++;
            $display("FAIL midrst_pre got=%02h exp=%02h", alu_out, e.out);
        end
        // Assert reset between edges; output must clear with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (alu_out !== 8'h00) begin
            bad++;
            $display("FAIL midrst_async_out got=%02h exp=00", alu_out);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if ({zero, carry, ovf} !== 3'b100) begin
            bad++;
            $display("FAIL midrst_async_flags got=%b exp=100", {zero, carry, ovf});
        end
`endif
        @(negedge clk);
        total++;
        if (alu_out !== 8'h00) begin
            bad++;
            $display("FAIL midrst_hold got=%02h exp=00", alu_out);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'h10, 8'h20, '{8'h30, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (alu_out !== e.out) begin
            bad++;
            $display("FAIL midrst_reissue got=%02h exp=%02h", alu_out, e.out);
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic       p;
        logic       ad;
        logic [7:0] aa;
        logic [7:0] bb;
        for (int i = 0; i < 60; i++) begin
            p  = 1'($urandom_range(0, 3) == 0);
            ad = 1'($urandom_range(0, 3) != 0);
            aa = 8'($urandom_range(0, 255));
            bb = 8'($urandom_range(0, 255));
            drive(p, ad, aa, bb, model(p, ad, aa, bb));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (alu_out !== e.out) begin
                bad++;
                $display("FAIL rand_out[%0d] got=%02h exp=%02h", i, alu_out, e.out);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
                bad++;
                $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {zero, carry, ovf}, {e.z, e.c, e.v});
            end
`endif
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        pass  = 1'b0;
        add   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        test_reset();
        test_pass();
        test_add();
        test_default();
        test_back_to_back();
        test_mid_reset();
        test_random();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
